// File: rtl/pico_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pico_pkg
// Purpose  : Shared types and default constants for the pico fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
package pico_pkg;

    localparam int c_psize_default    = 6;
    localparam int c_prog_len_default = 64;

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        ARM          = 2'd1,
        WAIT_PRESS   = 2'd2,
        WAIT_RELEASE = 2'd3
    } pc_state_t;

    function automatic logic is_stall_state(input pc_state_t s);
        return (s != RUN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Two-flop synchroniser followed by a consecutive-sample debouncer.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int              c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_cnt_w-1:0] r_cnt;

    // Level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program counter with go-button stall handshake for LOAD opcodes.
//            Optional PC_SINGLE_STEP_EN adds a step_mode input.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pico_pkg::*;
#(
    parameter int PSize           = c_psize_default,
    parameter int PROG_LEN        = c_prog_len_default,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCincr,
    input  logic             go_btn,
`ifdef PC_SINGLE_STEP_EN
    input  logic             step_mode,
`endif
    output logic [PSize-1:0] PCout,
    output logic             stalled,
    output logic             load_done
);

    localparam logic [PSize-1:0] c_pc_last = PSize'(PROG_LEN - 1);
    localparam logic [PSize-1:0] c_pc_one  = PSize'(1);

    pc_state_t        r_state;
    pc_state_t        w_state_nxt;
    logic [PSize-1:0] r_pc;
    logic [PSize-1:0] w_pc_nxt;
    logic [PSize-1:0] w_pc_inc;
    logic             r_stalled;
    logic             r_load_done;
    logic             w_load_done_nxt;
    logic             w_level;
    logic             w_advance_req;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .reset (reset),
        .raw   (go_btn),
        .level (w_level)
    );

`ifdef PC_SINGLE_STEP_EN
    assign w_advance_req = PCincr & ~step_mode;
`else
    assign w_advance_req = PCincr;
`endif

    assign w_pc_inc = (r_pc == c_pc_last) ? '0 : r_pc + c_pc_one;

    // ARM insists on a released button first, so a press held across the
    // start of a stall can never satisfy it.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_load_done_nxt = 1'b0;
        case (r_state)
            RUN: begin
                if (w_advance_req) begin
                    w_pc_nxt = w_pc_inc;
                end else begin
                    w_state_nxt = ARM;
                end
            end
            ARM: begin
                if (!w_level) begin
                    w_state_nxt = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (w_level) begin
                    w_state_nxt = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (!w_level) begin
                    w_pc_nxt        = w_pc_inc;
                    w_load_done_nxt = 1'b1;
                    w_state_nxt     = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_pc        <= '0;
            r_stalled   <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_stalled   <= is_stall_state(w_state_nxt);
            r_load_done <= w_load_done_nxt;
        end
    end

    assign PCout     = r_pc;
    assign stalled   = r_stalled;
    assign load_done = r_load_done;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer (PROG_LEN=8, debounce 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int PSIZE    = 6;
    localparam int PROG_LEN = 8;
    localparam int DEB      = 4;

    logic             clk;
    logic             reset;
    logic             PCincr;
    logic             go_btn;
    logic             step_mode;
    logic [PSIZE-1:0] PCout;
    logic             stalled;
    logic             load_done;

    int n_cmp   = 0;
    int n_bad   = 0;
    int ld_seen = 0;

    pc_sequencer #(
        .PSize           (PSIZE),
        .PROG_LEN        (PROG_LEN),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .PCincr    (PCincr),
        .go_btn    (go_btn),
`ifdef PC_SINGLE_STEP_EN
        .step_mode (step_mode),
`endif
        .PCout     (PCout),
        .stalled   (stalled),
        .load_done (load_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0=running, 1=armed, 2=awaiting press, 3=awaiting release
    int  m_pc     = 0;
    int  m_phase  = 0;
    bit  m_ld     = 1'b0;
    bit  m_lvl    = 1'b0;
    bit  m_valid  = 1'b0;
    bit  btn_q[$];
    bit  win[$];

    always @(posedge clk) begin
        bit s;
        bit all_diff;
        bit adv;
        if (reset) begin
            m_pc    = 0;
            m_phase = 0;
            m_ld    = 1'b0;
            m_lvl   = 1'b0;
            m_valid = 1'b1;
            btn_q.delete();
            win.delete();
        end else begin
`ifdef PC_SINGLE_STEP_EN
            adv = PCincr && !step_mode;
`else
            adv = PCincr;
`endif
            m_ld = 1'b0;
            case (m_phase)
                0: if (adv) m_pc = (m_pc + 1) % PROG_LEN; else m_phase = 1;
                1: if (!m_lvl) m_phase = 2;
                2: if (m_lvl) m_phase = 3;
                default: if (!m_lvl) begin
                    m_pc    = (m_pc + 1) % PROG_LEN;
                    m_ld    = 1'b1;
                    m_phase = 0;
                end
            endcase
            // Button as seen two edges ago; level flips after DEB disagreeing samples in a row.
            s = (btn_q.size() >= 2) ? btn_q[btn_q.size() - 2] : 1'b0;
            btn_q.push_back(go_btn);
            win.push_back(s);
            if (win.size() > DEB) void'(win.pop_front());
            all_diff = (win.size() == DEB);
            foreach (win[i]) if (win[i] == m_lvl) all_diff = 1'b0;
            if (all_diff) begin
                m_lvl = !m_lvl;
                win.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model.pc", int'(PCout), m_pc);
            chk("model.stalled", int'(stalled), (m_phase != 0) ? 1 : 0);
            chk("model.load_done", int'(load_done), int'(m_ld));
            if (load_done === 1'b1) ld_seen++;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string tag, input int pc, input int st, input int ld);
        chk({tag, ".pc"}, int'(PCout), pc);
        chk({tag, ".stalled"}, int'(stalled), st);
        chk({tag, ".load_done"}, int'(load_done), ld);
    endtask

    // Long press then release; the release is seen by the FSM on the 7th edge.
    task automatic press_release_pre();
        go_btn = 1'b1;
        tick(10);
        go_btn = 1'b0;
        tick(6);
    endtask

    initial begin
        reset     = 1'b1;
        PCincr    = 1'b1;
        go_btn    = 1'b0;
        step_mode = 1'b0;
        tick(2);
        expect_out("reset", 0, 0, 0);
        reset = 1'b0;

        tick(10);
        chk("run10.pc", int'(PCout), 2);
        chk("run10.no_load_done", ld_seen, 0);
        tick(1);

        PCincr = 1'b0;
        tick(1);
        expect_out("stall_entry", 3, 1, 0);
        tick(3);
        expect_out("stall_hold", 3, 1, 0);
        press_release_pre();
        expect_out("pre_release", 3, 1, 0);
        tick(1);
        expect_out("release", 4, 0, 1);
        PCincr = 1'b1;
        tick(1);
        expect_out("after_release", 5, 0, 0);

        PCincr = 1'b0;
        tick(3);
        press_release_pre();
        tick(1);
        expect_out("load5", 6, 0, 1);
        tick(1);
        expect_out("load6_arm", 6, 1, 0);
        tick(20);
        expect_out("load6_hold", 6, 1, 0);
        press_release_pre();
        tick(1);
        expect_out("load6", 7, 0, 1);

        tick(3);
        go_btn = 1'b1;
        tick(3);
        go_btn = 1'b0;
        tick(10);
        expect_out("glitch", 7, 1, 0);
        go_btn = 1'b1;
        tick(10);
        expect_out("wait_release", 7, 1, 0);
        reset = 1'b1;
        tick(1);
        expect_out("reset_in_stall", 0, 0, 0);
        reset  = 1'b0;
        PCincr = 1'b1;

        tick(6);
        expect_out("run_held", 6, 0, 0);
        PCincr = 1'b0;
        tick(1);
        tick(10);
        expect_out("held_no_advance", 6, 1, 0);
        go_btn = 1'b0;
        tick(7);
        expect_out("held_release_no_advance", 6, 1, 0);
        tick(3);
        press_release_pre();
        expect_out("held_pre_release", 6, 1, 0);
        tick(1);
        expect_out("held_fresh_press", 7, 0, 1);

        tick(3);
        press_release_pre();
        tick(1);
        expect_out("release_wrap", 0, 0, 1);
        PCincr = 1'b1;
        tick(1);
        expect_out("run_after_wrap", 1, 0, 0);

`ifdef PC_SINGLE_STEP_EN
        step_mode = 1'b1;
        tick(1);
        expect_out("step_arm", 1, 1, 0);
        tick(2);
        press_release_pre();
        tick(1);
        expect_out("step1", 2, 0, 1);
        tick(3);
        press_release_pre();
        tick(1);
        expect_out("step2", 3, 0, 1);
        step_mode = 1'b0;
        tick(1);
        expect_out("step_off", 4, 0, 0);
`endif

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program counter and fetch sequencer directly upstream of the opcode decoder; drives the program-memory address each cycle.
- Consumes the decoder's PCincr. PCincr=1 advances the PC. PCincr=0 (LOAD) holds the PC until the operator completes a debounced press-and-release of the go button, then advances.
- Owns the button synchroniser, the debouncer and the stall FSM, so the decoder stays purely combinational.

Parameters:
- PSize, 6, PC / program-memory address width in bits.
- PROG_LEN, 64, number of program words; PC wraps from PROG_LEN-1 to 0. Legal range 2..2**PSize.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples needed before the debounced level changes. Must be ≥1.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- PCincr, input, 1, from decoder: 1 = advance, 0 = stall for button.
- go_btn, input, 1, raw asynchronous push-button (SW8), active-high.
- PCout, output, PSize, current instruction address.
- stalled, output, 1, high whenever the FSM is not in RUN.
- load_done, output, 1, one-cycle pulse on the cycle the stall releases.

Behaviour:
- Reset values: PCout=0, FSM=RUN, stalled=0, load_done=0, both sync flops=0, debounced level=0, debounce counter=0. Reset takes priority over all other events. Reset during a stall returns the FSM to RUN with PC=0.
- Synchroniser: 2 flops, giving 2 cycles of latency from go_btn to the synchronised sample.
- Debouncer:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - While the synchronised sample equals the debounced level, the counter clears to 0.
  - While it differs, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the sample still differs, the debounced level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the level.
- FSM states are RUN, ARM, WAIT_PRESS and WAIT_RELEASE. All transitions are registered.
  - RUN, PCincr=1: PC <= (PC==PROG_LEN-1) ? 0 : PC+1.
  - RUN, PCincr=0: PC held. Go to ARM.
  - ARM: PC held. When debounced=0, go to WAIT_PRESS. A button already held when the stall begins therefore cannot satisfy the LOAD.
  - WAIT_PRESS: PC held. When debounced=1, go to WAIT_RELEASE.
  - WAIT_RELEASE: PC held. When debounced=0, PC advances with the same wrap rule, load_done=1 for that cycle, and the FSM goes to RUN.
- PCincr is sampled only in RUN and ignored in the other states. The decoder continues writing the switch value every stalled cycle; the last write before release is the one retained.
- Back-to-back LOADs each require their own full release→press→release sequence; one press never consumes two LOADs.
- PC wrap applies identically on the RUN path and the release path.
- stalled is a registered decode of the state: high in ARM, WAIT_PRESS and WAIT_RELEASE, low in RUN.

Optional Feature:
- Macro: PC_SINGLE_STEP_EN.
- Defined: adds input step_mode (1 bit), placed after go_btn. When step_mode=1, RUN treats every instruction as PCincr=0, so each instruction needs a press/release. load_done pulses on every step. step_mode is sampled only in RUN.
- Undefined: no step_mode port; behaviour exactly as above.

Decomposition:
- Shared package pico_pkg (alongside the existing opcode definitions):
  - typedef enum logic [1:0] {RUN, ARM, WAIT_PRESS, WAIT_RELEASE} pc_state_t.
  - Default constants for PSize and PROG_LEN.
- One natural sub-module: btn_debounce (synchroniser plus debounce counter; params DEBOUNCE_CYCLES; ports clk, reset, raw, level). The FSM and PC register stay in pc_sequencer.

Test Plan (PSize=6, PROG_LEN=8, DEBOUNCE_CYCLES=4):
- Reset then PCincr=1 for 10 cycles → PCout 0,1,…,7,0,1; stalled=0; load_done never asserted.
- PC=3 and PCincr=0 with go_btn low → PC holds 3, stalled=1 next cycle. Press go_btn for 10 cycles then release → PCout=4 exactly 2+4 cycles after release is visible; load_done is a single 1-cycle pulse; stalled=0 afterwards.
- go_btn already high when the stall begins → no advance until release, then a fresh press and release; PC advances once only.
- 3-cycle glitch on go_btn during WAIT_PRESS → state and PC unchanged.
- Two consecutive LOADs at PC=5,6 with one long press → PC stops at 6. A second press/release gives PC=7.
- reset asserted in WAIT_RELEASE at PC=7 → next cycle PCout=0, stalled=0, FSM=RUN. With PC_SINGLE_STEP_EN and step_mode=1, each press/release advances PC by exactly 1.
